// File: rtl/quiz_pkg.sv
// Shared types and constants for the quiz round controller.
package quiz_pkg;

  typedef enum logic [2:0] {IDLE, ASK, JUDGE, SHOW, NEXT, DONE} state_t;

  localparam logic [1:0] PL_NONE = 2'd0;
  localparam logic [1:0] PL_P1   = 2'd1;
  localparam logic [1:0] PL_P2   = 2'd2;

  // Remote bus layout: P1 answers 1..4 on bits 7..4, P2 answers 1..4 on bits 3..0.
  localparam int         KEY_P1_HI = 7;
  localparam int         KEY_P2_HI = 3;
  localparam logic [7:0] KEYS_IDLE = 8'hFF;

  typedef struct packed {
    logic [1:0] player;
    logic [2:0] ans;
  } key_t;

  // Decode a single low bit into (player, answer); result is meaningless unless one-hot-low.
  function automatic key_t decode_key(input logic [7:0] s);
    key_t k;
    k = '0;
    for (int i = 0; i < 8; i++) begin
      if (!s[i]) begin
        k.player = (i > KEY_P2_HI) ? PL_P1 : PL_P2;
        k.ans    = (i > KEY_P2_HI) ? 3'(KEY_P1_HI + 1 - i) : 3'(KEY_P2_HI + 1 - i);
      end
    end
    return k;
  endfunction

endpackage

// File: rtl/remote_key_sync.sv
// Remote key front end: 2-flop synchroniser, one-hot-low decode and
// release tracking so that each physical press yields a single strobe.
module remote_key_sync
  import quiz_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rm_in_bcd,
  output logic       press,
  output logic [1:0] player,
  output logic [2:0] ans
);

  logic [1:0][7:0] sync_pipe;
  logic [7:0]      sample;
  logic            valid;
  logic            armed;
  key_t            key;

  // Two-stage synchroniser; idles at all-ones (no key down).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_pipe <= {2{KEYS_IDLE}};
    else        sync_pipe <= {sync_pipe[0], rm_in_bcd};
  end

  assign sample = sync_pipe[1];
  assign valid  = $onehot(~sample);
  assign key    = decode_key(sample);

  // Re-arm only on a full release; a chord (multi-low) leaves armed untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 armed <= 1'b0;
    else if (sample == KEYS_IDLE) armed <= 1'b1;
    else if (valid && armed)      armed <= 1'b0;
  end

  assign press  = valid && armed;
  assign player = key.player;
  assign ans    = key.ans;

endmodule

// File: rtl/quiz_round_ctrl.sv
// Quiz round sequencer: judges remote presses against the problem answer,
// keeps both scores and walks the problem index.
// Optional feature macro QUIZ_LOCKOUT_EN: a wrong answer locks that player
// out for the rest of the problem.
module quiz_round_ctrl
  import quiz_pkg::*;
#(
  parameter int NUM_PROBLEMS = 8,
  parameter int IDX_W        = 3,
  parameter int SCORE_W      = 4,
  parameter int TIMEOUT_CYC  = 1000,
  parameter int HOLD_CYC     = 50
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [7:0]         rm_in_bcd,
  input  logic [2:0]         prob_ans,
  output logic [IDX_W-1:0]   prob_idx,
  output logic [SCORE_W-1:0] score_p1,
  output logic [SCORE_W-1:0] score_p2,
  output logic               busy,
  output logic               result_valid,
  output logic [1:0]         result_player,
  output logic               result_correct,
  output logic               game_over
);

  localparam int TMR_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int HOLD_W = $clog2(HOLD_CYC + 1);

  state_t            state;
  logic [TMR_W-1:0]  timer;
  logic [HOLD_W-1:0] hold_cnt;
  logic [1:0]        cur_player;
  logic [2:0]        cur_ans;
  logic              key_press;
  logic [1:0]        key_player;
  logic [2:0]        key_ans;
  logic              press_live;
  logic              judge_ok;
  logic              timeout_hit;
  logic              last_live;

  remote_key_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .rm_in_bcd (rm_in_bcd),
    .press     (key_press),
    .player    (key_player),
    .ans       (key_ans)
  );

`ifdef QUIZ_LOCKOUT_EN
  logic [1:0] locked;  // bit0 = P1, bit1 = P2
  assign press_live = key_press && !locked[key_player == PL_P2];
  // Wrong answer ends the problem when the other player is already out.
  assign last_live  = locked[cur_player == PL_P1];
`else
  assign press_live = key_press;
  assign last_live  = 1'b0;
`endif

  assign judge_ok    = (cur_ans == prob_ans);
  // A press arriving on the final timer cycle wins over the timeout.
  assign timeout_hit = (state == ASK) && !press_live && (timer >= TMR_W'(TIMEOUT_CYC - 1));

  // Result strobe marks the cycle whose closing edge commits score/result.
  always_comb begin
    result_valid = 1'b0;
    if (timeout_hit)                               result_valid = 1'b1;
    if (state == JUDGE && (judge_ok || last_live)) result_valid = 1'b1;
  end

  assign busy      = (state != IDLE) && (state != DONE);
  assign game_over = (state == DONE);

  // Main round FSM with score, index, timer and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      prob_idx       <= '0;
      score_p1       <= '0;
      score_p2       <= '0;
      timer          <= '0;
      hold_cnt       <= '0;
      cur_player     <= PL_NONE;
      cur_ans        <= '0;
      result_player  <= PL_NONE;
      result_correct <= 1'b0;
`ifdef QUIZ_LOCKOUT_EN
      locked         <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= ASK;
            prob_idx <= '0;
            score_p1 <= '0;
            score_p2 <= '0;
            timer    <= '0;
`ifdef QUIZ_LOCKOUT_EN
            locked   <= '0;
`endif
          end
        end
        ASK: begin
          if (press_live) begin
            cur_player <= key_player;
            cur_ans    <= key_ans;
            timer      <= timer + 1'b1;
            state      <= JUDGE;
          end else if (timeout_hit) begin
            result_player  <= PL_NONE;
            result_correct <= 1'b0;
            hold_cnt       <= '0;
            state          <= SHOW;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        JUDGE: begin
          hold_cnt <= '0;
          if (judge_ok) begin
            if (cur_player == PL_P1) begin
              if (score_p1 != '1) score_p1 <= score_p1 + 1'b1;
            end else begin
              if (score_p2 != '1) score_p2 <= score_p2 + 1'b1;
            end
            result_player  <= cur_player;
            result_correct <= 1'b1;
            state          <= SHOW;
          end else begin
`ifdef QUIZ_LOCKOUT_EN
            locked[cur_player == PL_P2] <= 1'b1;
`endif
            if (last_live) begin
              result_player  <= cur_player;
              result_correct <= 1'b0;
              state          <= SHOW;
            end else begin
              state <= ASK;
            end
          end
        end
        SHOW: begin
          if (hold_cnt == HOLD_W'(HOLD_CYC - 1)) state <= NEXT;
          else                                   hold_cnt <= hold_cnt + 1'b1;
        end
        NEXT: begin
          timer <= '0;
`ifdef QUIZ_LOCKOUT_EN
          locked <= '0;
`endif
          if (prob_idx == IDX_W'(NUM_PROBLEMS - 1)) begin
            state <= DONE;
          end else begin
            prob_idx <= prob_idx + 1'b1;
            state    <= ASK;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_quiz_round_ctrl.sv
// Bench for quiz_round_ctrl: scenario tasks plus a randomized game checked
// against a problem-level score model. Honors QUIZ_LOCKOUT_EN if defined.
module tb_quiz_round_ctrl;

  localparam int NP = 8;
  localparam int TO = 40;
  localparam int HC = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] rm = 8'hFF;
  logic [2:0] prob_ans;
  logic [2:0] ans_tab [0:NP-1];

  logic [2:0] prob_idx, t_idx;
  logic [3:0] score_p1, score_p2;
  logic [1:0] t_s1, t_s2;
  logic       busy, result_valid, result_correct, game_over;
  logic [1:0] result_player;
  logic       t_busy, t_rv, t_rc, t_go;
  logic [1:0] t_rp;

  int checks = 0, failures = 0, rv_cnt = 0;
  int exp_s1 = 0, exp_s2 = 0, exp_t1 = 0, exp_t2 = 0;

  quiz_round_ctrl #(.NUM_PROBLEMS(NP), .IDX_W(3), .SCORE_W(4), .TIMEOUT_CYC(TO), .HOLD_CYC(HC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rm_in_bcd(rm), .prob_ans(prob_ans),
    .prob_idx(prob_idx), .score_p1(score_p1), .score_p2(score_p2), .busy(busy),
    .result_valid(result_valid), .result_player(result_player),
    .result_correct(result_correct), .game_over(game_over));

  // Narrow-score twin fed identically, used for saturation checks.
  quiz_round_ctrl #(.NUM_PROBLEMS(NP), .IDX_W(3), .SCORE_W(2), .TIMEOUT_CYC(TO), .HOLD_CYC(HC)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .rm_in_bcd(rm), .prob_ans(prob_ans),
    .prob_idx(t_idx), .score_p1(t_s1), .score_p2(t_s2), .busy(t_busy),
    .result_valid(t_rv), .result_player(t_rp), .result_correct(t_rc), .game_over(t_go));

  always #5 clk = ~clk;
  assign prob_ans = ans_tab[prob_idx];

  always @(negedge clk) if (result_valid === 1'b1) rv_cnt++;

  function automatic logic [7:0] key_of(input int p, input int a);
    logic [7:0] k;
    k = 8'hFF;
    k[(p == 1 ? 7 : 3) - (a - 1)] = 1'b0;
    return k;
  endfunction

  function automatic int wrong_of(input int a);
    return (a % 4) + 1;
  endfunction

  // Reference model: a correct answer earns one point, capped at the counter's max.
  task automatic award(input int p);
    if (p == 1) begin
      exp_s1 = (exp_s1 + 1 > 15) ? 15 : exp_s1 + 1;
      exp_t1 = (exp_t1 + 1 > 3) ? 3 : exp_t1 + 1;
    end else begin
      exp_s2 = (exp_s2 + 1 > 15) ? 15 : exp_s2 + 1;
      exp_t2 = (exp_t2 + 1 > 3) ? 3 : exp_t2 + 1;
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic press(input logic [7:0] k, input int hold);
    rm = k;
    repeat (hold) tick();
    rm = 8'hFF;
    repeat (3) tick();
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
    exp_s1 = 0; exp_s2 = 0; exp_t1 = 0; exp_t2 = 0;
  endtask

  task automatic wait_next(input logic [2:0] old);
    bit ok;
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      if (prob_idx !== old || game_over === 1'b1) begin ok = 1; break; end
      tick();
    end
    checks++;
    if (!ok) begin failures++; $display("FAIL wait_next idx=%0d never advanced", old); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    checks++;
    if ({prob_idx, score_p1, score_p2, busy, result_valid, result_player, result_correct, game_over} !== 16'h0) begin
      failures++; $display("FAIL reset_outputs got=%h exp=0", {prob_idx, score_p1, score_p2, busy, result_valid, result_player, result_correct, game_over});
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if ({busy, game_over, t_s1, t_s2} !== 6'h0) begin
      failures++; $display("FAIL reset_idle got=%h exp=0", {busy, game_over, t_s1, t_s2});
    end
  endtask

  task automatic test_basic();
    int n, m;
    ans_tab[0] = 3'd3;
    do_start();
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL start_busy got=%b exp=1", busy); end
    rm = 8'b11011111;
    n = 0;
    while (result_valid !== 1'b1 && n < 10) begin tick(); n++; end
    rm = 8'hFF;
    checks++;
    if (n != 3) begin failures++; $display("FAIL press_to_judge got=%0d exp=3", n); end
    tick();
    award(1);
    checks++;
    if (score_p1 !== 4'(exp_s1) || result_player !== 2'd1 || result_correct !== 1'b1) begin
      failures++; $display("FAIL basic_result got=s1 %0d p %0d c %b exp=s1 %0d p 1 c 1", score_p1, result_player, result_correct, exp_s1);
    end
    m = 1;
    while (prob_idx !== 3'd1 && m < 40) begin tick(); m++; end
    checks++;
    if (m != HC + 2) begin failures++; $display("FAIL judge_to_next got=%0d exp=%0d", m, HC + 2); end
  endtask

  task automatic test_held_key();
    int rv0;
    ans_tab[1] = 3'd1; ans_tab[2] = 3'd1;
    rv0 = rv_cnt;
    rm = key_of(1, 1);
    repeat (20) tick();
    rm = 8'hFF;
    repeat (3) tick();
    award(1);
    checks++;
    if (rv_cnt - rv0 != 1 || prob_idx !== 3'd2 || score_p1 !== 4'(exp_s1)) begin
      failures++; $display("FAIL held_once got=rv %0d idx %0d s1 %0d exp=rv 1 idx 2 s1 %0d", rv_cnt - rv0, prob_idx, score_p1, exp_s1);
    end
    press(key_of(1, 1), 3);
    award(1);
    wait_next(3'd2);
    checks++;
    if (rv_cnt - rv0 != 2 || score_p1 !== 4'(exp_s1) || prob_idx !== 3'd3) begin
      failures++; $display("FAIL held_repress got=rv %0d s1 %0d idx %0d exp=rv 2 s1 %0d idx 3", rv_cnt - rv0, score_p1, prob_idx, exp_s1);
    end
  endtask

  task automatic test_lockout();
    int rv0;
    ans_tab[3] = 3'd2;
    rv0 = rv_cnt;
    press(key_of(2, 3), 3);
    checks++;
    if (rv_cnt != rv0 || prob_idx !== 3'd3) begin
      failures++; $display("FAIL wrong_no_result got=rv %0d idx %0d exp=rv 0 idx 3", rv_cnt - rv0, prob_idx);
    end
`ifdef QUIZ_LOCKOUT_EN
    press(key_of(2, 2), 3);
    checks++;
    if (rv_cnt != rv0 || score_p2 !== 4'(exp_s2)) begin
      failures++; $display("FAIL locked_ignored got=rv %0d s2 %0d exp=rv 0 s2 %0d", rv_cnt - rv0, score_p2, exp_s2);
    end
    press(key_of(1, 2), 3);
    award(1);
    checks++;
    if (rv_cnt - rv0 != 1 || result_player !== 2'd1 || score_p1 !== 4'(exp_s1)) begin
      failures++; $display("FAIL other_scores got=rv %0d p %0d s1 %0d exp=rv 1 p 1 s1 %0d", rv_cnt - rv0, result_player, score_p1, exp_s1);
    end
`else
    press(key_of(2, 2), 3);
    award(2);
    checks++;
    if (rv_cnt - rv0 != 1 || result_player !== 2'd2 || score_p2 !== 4'(exp_s2)) begin
      failures++; $display("FAIL retry_scores got=rv %0d p %0d s2 %0d exp=rv 1 p 2 s2 %0d", rv_cnt - rv0, result_player, score_p2, exp_s2);
    end
`endif
    wait_next(3'd3);
  endtask

  task automatic test_both_wrong();
    int rv0, a;
    a = $urandom_range(1, 4);
    ans_tab[4] = 3'(a);
    rv0 = rv_cnt;
    press(key_of(1, wrong_of(a)), 3);
    press(key_of(2, wrong_of(a)), 3);
`ifdef QUIZ_LOCKOUT_EN
    checks++;
    if (rv_cnt - rv0 != 1 || result_player !== 2'd2 || result_correct !== 1'b0) begin
      failures++; $display("FAIL both_wrong got=rv %0d p %0d c %b exp=rv 1 p 2 c 0", rv_cnt - rv0, result_player, result_correct);
    end
    wait_next(3'd4);
`else
    checks++;
    if (rv_cnt != rv0 || prob_idx !== 3'd4) begin
      failures++; $display("FAIL both_wrong_stay got=rv %0d idx %0d exp=rv 0 idx 4", rv_cnt - rv0, prob_idx);
    end
    wait_next(3'd4);
    checks++;
    if (rv_cnt - rv0 != 1 || result_player !== 2'd0 || result_correct !== 1'b0) begin
      failures++; $display("FAIL both_wrong_timeout got=rv %0d p %0d c %b exp=rv 1 p 0 c 0", rv_cnt - rv0, result_player, result_correct);
    end
`endif
    checks++;
    if (score_p1 !== 4'(exp_s1) || score_p2 !== 4'(exp_s2)) begin
      failures++; $display("FAIL both_wrong_scores got=%0d/%0d exp=%0d/%0d", score_p1, score_p2, exp_s1, exp_s2);
    end
  endtask

  task automatic test_timeout();
    int n, rv0;
    rv0 = rv_cnt;
    n = 0;
    while (result_valid !== 1'b1 && n < 100) begin tick(); n++; end
    checks++;
    if (n != TO - 1) begin failures++; $display("FAIL timeout_cycles got=%0d exp=%0d", n, TO - 1); end
    tick();
    checks++;
    if (rv_cnt - rv0 != 1 || result_player !== 2'd0 || result_correct !== 1'b0 ||
        score_p1 !== 4'(exp_s1) || score_p2 !== 4'(exp_s2)) begin
      failures++; $display("FAIL timeout_result got=rv %0d p %0d c %b s %0d/%0d exp=rv 1 p 0 c 0 s %0d/%0d",
                           rv_cnt - rv0, result_player, result_correct, score_p1, score_p2, exp_s1, exp_s2);
    end
    wait_next(3'd5);
  endtask

  task automatic test_finish_game();
    for (int i = 6; i < NP; i++) begin
      ans_tab[i] = 3'($urandom_range(1, 4));
      press(key_of(2, int'(ans_tab[i])), 3);
      award(2);
      wait_next(3'(i));
    end
    checks++;
    if (game_over !== 1'b1 || busy !== 1'b0 || prob_idx !== 3'(NP - 1) || score_p2 !== 4'(exp_s2)) begin
      failures++; $display("FAIL game_end got=go %b busy %b idx %0d s2 %0d exp=go 1 busy 0 idx %0d s2 %0d",
                           game_over, busy, prob_idx, score_p2, NP - 1, exp_s2);
    end
  endtask

  task automatic test_full_game();
    do_start();
    checks++;
    if (prob_idx !== 3'd0 || score_p1 !== 4'd0 || score_p2 !== 4'd0 || game_over !== 1'b0) begin
      failures++; $display("FAIL restart_clear got=idx %0d s %0d/%0d go %b exp=0", prob_idx, score_p1, score_p2, game_over);
    end
    for (int i = 0; i < NP; i++) begin
      ans_tab[i] = 3'($urandom_range(1, 4));
      press(key_of(1, int'(ans_tab[i])), 3);
      award(1);
      wait_next(3'(i));
    end
    checks++;
    if (game_over !== 1'b1 || score_p1 !== 4'd8 || t_s1 !== 2'd3 || prob_idx !== 3'd7) begin
      failures++; $display("FAIL full_game got=go %b s1 %0d sat %0d idx %0d exp=go 1 s1 8 sat 3 idx 7",
                           game_over, score_p1, t_s1, prob_idx);
    end
  endtask

  task automatic test_random_game();
    int a, act, ep;
    logic ec;
    do_start();
    for (int i = 0; i < NP; i++) begin
      a = $urandom_range(1, 4);
      ans_tab[i] = 3'(a);
      act = $urandom_range(0, 3);
      ep = 0; ec = 1'b0;
      case (act)
        0: begin press(key_of(1, a), 3); award(1); ep = 1; ec = 1'b1; end
        1: begin press(key_of(2, a), 3); award(2); ep = 2; ec = 1'b1; end
        2: begin press(key_of(1, wrong_of(a)), 3); press(key_of(2, a), 3); award(2); ep = 2; ec = 1'b1; end
        default: ;
      endcase
      wait_next(3'(i));
      checks++;
      if (score_p1 !== 4'(exp_s1) || score_p2 !== 4'(exp_s2) || t_s1 !== 2'(exp_t1) || t_s2 !== 2'(exp_t2) ||
          result_player !== 2'(ep) || result_correct !== ec) begin
        failures++; $display("FAIL rand_prob%0d act %0d got=s %0d/%0d t %0d/%0d p %0d c %b exp=s %0d/%0d t %0d/%0d p %0d c %b",
                             i, act, score_p1, score_p2, t_s1, t_s2, result_player, result_correct,
                             exp_s1, exp_s2, exp_t1, exp_t2, ep, ec);
      end
    end
    checks++;
    if (game_over !== 1'b1) begin failures++; $display("FAIL rand_done got=%b exp=1", game_over); end
  endtask

  task automatic test_reset_in_show();
    ans_tab[0] = 3'd1;
    do_start();
    press(key_of(1, 1), 3);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({prob_idx, score_p1, score_p2, busy, result_valid, result_player, result_correct, game_over, t_s1} !== 18'h0) begin
      failures++; $display("FAIL reset_in_show got=%h exp=0",
                           {prob_idx, score_p1, score_p2, busy, result_valid, result_player, result_correct, game_over, t_s1});
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    for (int i = 0; i < NP; i++) ans_tab[i] = 3'd1;
    test_reset();
    test_basic();
    test_held_key();
    test_lockout();
    test_both_wrong();
    test_timeout();
    test_finish_game();
    test_full_game();
    test_random_game();
    test_reset_in_show();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
